fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that drives the Imem read address and owns the fetch PC.
- Imem is read-only and combinational: `imem_instr` is valid in the same cycle as `imem_addr`.
- Buffers fetched words in a 2-entry FIFO and hands {pc, instruction} to decode over a valid/ready handshake.
- Handles branch/jump redirects, halt requests and fetch faults (misaligned or out-of-range PC).

---
 rtl/fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with 2-entry output FIFO
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault
);

    localparam logic [31:0] LP_WORDS = 32'(IMEM_WORDS);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_pc_q  [2];
    logic [31:0] r_ins_q [2];
    logic        r_head;
    logic        r_tail;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic        w_flush;
    logic        w_misaligned;
    logic        w_in_range;

    assign out_valid    = (r_count != 2'd0);
    assign out_pc       = r_pc_q[r_head];
    assign out_instr    = r_ins_q[r_head];
    assign imem_addr    = r_fetch_pc;
    assign fault        = (r_state == S_FAULT);
    assign w_pop        = out_valid & out_ready;
    assign w_in_range   = ({2'b00, r_fetch_pc[31:2]} < LP_WORDS);
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    // A fault freezes the block, so redirects only flush outside FAULT.
    assign w_flush      = redirect_valid & (r_state != S_FAULT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and push decision; redirect outranks halt, halt outranks the range check.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        case (r_state)
            S_RUN: begin
                if (redirect_valid) begin
                    if (w_misaligned) begin
                        w_next_state = S_FAULT;
                    end
                end else if (halt_req) begin
                    w_next_state = S_HALT;
                end else if (!w_in_range) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_push = (r_count != 2'd2) | w_pop;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    if (w_misaligned) begin
                        w_next_state = S_FAULT;
                    end
                end else if (!halt_req) begin
                    w_next_state = S_RUN;
                end
            end
            S_FAULT: begin
                w_next_state = S_FAULT;
            end
            default: begin
                w_next_state = S_FAULT;
            end
        endcase
    end

    // Fetch PC: load on an aligned redirect, advance by one word on each push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_flush) begin
            if (!w_misaligned) begin
                r_fetch_pc <= redirect_pc;
            end
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Two-entry FIFO; a flush empties it regardless of any same-cycle pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_q[0]  <= 32'd0;
            r_pc_q[1]  <= 32'd0;
            r_ins_q[0] <= 32'd0;
            r_ins_q[1] <= 32'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_count    <= 2'd0;
        end else if (w_flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc_q[r_tail]  <= r_fetch_pc;
                r_ins_q[r_tail] <= imem_instr;
                r_tail          <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: PCs waiting for decode, fetch PC, halt and fault flags.
    logic [31:0] q_pc [$];
    logic [31:0] m_pc    = RESET_PC;
    logic        m_halt  = 1'b0;
    logic        m_fault = 1'b0;

    fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_instr = imem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model advances once per edge from the inputs seen at that edge.
    initial begin
        logic pop;
        logic room;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q_pc.delete();
                m_pc    = RESET_PC;
                m_halt  = 1'b0;
                m_fault = 1'b0;
            end else begin
                pop = (q_pc.size() > 0) && out_ready;
                if (m_fault) begin
                    if (pop) void'(q_pc.pop_front());
                end else if (redirect_valid) begin
                    q_pc.delete();
                    if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
                    else m_pc = redirect_pc;
                end else begin
                    room = (q_pc.size() < 2) || pop;
                    if (pop) void'(q_pc.pop_front());
                    if (!m_halt && !halt_req) begin
                        if ({2'b00, m_pc[31:2]} >= 32'(IMEM_WORDS)) m_fault = 1'b1;
                        else if (room) begin
                            q_pc.push_back(m_pc);
                            m_pc = m_pc + 32'd4;
                        end
                    end
                    m_halt = halt_req;
                end
            end
        end
    end

    // Compare DUT against the reference on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_valid", {31'd0, out_valid}, {31'd0, q_pc.size() > 0});
            if (q_pc.size() > 0) begin
                chk("model_pc", out_pc, q_pc[0]);
                chk("model_instr", out_instr, imem_word(q_pc[0]));
            end
            chk("model_addr", imem_addr, m_pc);
            chk("model_fault", {31'd0, fault}, {31'd0, m_fault});
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Stream at full rate.
        rst = 1'b0; out_ready = 1'b1;
        tick();
        chk("s_valid", {31'd0, out_valid}, 32'd1);
        chk("s_pc0", out_pc, 32'h0);
        chk("s_in0", out_instr, 32'h1000_0000);
        tick(); chk("s_pc4", out_pc, 32'h4); chk("s_in1", out_instr, 32'h1000_0001);
        tick(); chk("s_pc8", out_pc, 32'h8);
        tick(); chk("s_pcC", out_pc, 32'hC); chk("s_in3", out_instr, 32'h1000_0003);

        // Backpressure: fill, stall, then drain.
        rst = 1'b1; tick();
        rst = 1'b0; out_ready = 1'b0;
        tick(); tick(); tick();
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_pc", out_pc, 32'h0);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick(); chk("bp_d4", out_pc, 32'h4);
        tick(); chk("bp_d8", out_pc, 32'h8);
        tick(); chk("bp_dC", out_pc, 32'hC);

        // Redirect with a full FIFO.
        rst = 1'b1; tick();
        rst = 1'b0; out_ready = 1'b0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        chk("rd_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h40);
        tick();
        chk("rd_pc", out_pc, 32'h40);
        chk("rd_instr", out_instr, 32'h1000_0010);
        tick();
        chk("rd_pc2", out_pc, 32'h44);

        // Misaligned redirect faults and freezes the PC.
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        chk("ma_fault", {31'd0, fault}, 32'd1);
        chk("ma_addr", imem_addr, 32'h48);
        chk("ma_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("ma_ign_addr", imem_addr, 32'h48);
        chk("ma_ign_fault", {31'd0, fault}, 32'd1);
        rst = 1'b1; tick();
        chk("ma_clr", {31'd0, fault}, 32'd0);

        // Last word of Imem, then out-of-range fault while an entry is still buffered.
        rst = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("or_pc", out_pc, 32'hFFC);
        chk("or_instr", out_instr, 32'h1000_03FF);
        out_ready = 1'b0;
        tick();
        chk("or_fault", {31'd0, fault}, 32'd1);
        chk("or_addr", imem_addr, 32'h1000);
        chk("or_hold", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("or_drain", {31'd0, out_valid}, 32'd0);

        // Halt mid-stream, drain, resume, then asynchronous reset.
        rst = 1'b1; tick();
        rst = 1'b0;
        tick(); tick();
        halt_req = 1'b1; out_ready = 1'b0;
        tick(); tick();
        chk("h_addr", imem_addr, 32'h8);
        chk("h_pc", out_pc, 32'h4);
        out_ready = 1'b1;
        tick();
        chk("h_empty", {31'd0, out_valid}, 32'd0);
        chk("h_addr2", imem_addr, 32'h8);
        halt_req = 1'b0;
        tick(); tick();
        chk("h_resume", out_pc, 32'h8);
        chk("h_addr3", imem_addr, 32'hC);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_addr", imem_addr, RESET_PC);
        tick();
        rst = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
